cam_subarray_ctrl: RTL
======================

Name: cam_subarray_ctrl

Overview:
- Initiator-side sequencer that drives one CAM subarray's operation port; the subarray is the responder.
- Accepts one-at-a-time commands over a valid/ready interface and applies them to the subarray pins with correct chip_enable timing.
- For writes and updates, waits for the write_done pulse and then releases chip_enable. For searches (modes 010–110), captures the registered tag result.
- Returns exactly one response per command over a valid/ready interface. Sits between the vector-search scheduler and each subarray instance.

Parameters:
- DONE_TIMEOUT, 15: max cycles in WAIT_DONE before aborting with error.
- TO_W, 4: width of the timeout counter. Must satisfy 2^TO_W > DONE_TIMEOUT.

Ports:
- CLK  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  3  operation_mode code (000 write, 001 update, 010–110 search, 111 illegal).
- cmd_addr_sel  in  1  0: cmp address, 1: ppg address.
- cmd_cmp_addr  in  10  cmp address(es).
- cmd_ppg_addr  in  4  ppg address(es).
- cmd_cmp_data  in  2  cmp search bits.
- cmd_ppg_data  in  2  ppg search bits.
- cmd_data  in  16  write data.
- cmd_tag  in  16  update mask.
- cmd_update  in  1  update bit value.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_tag  out  16  search result; 0 for write/update/error.
- rsp_err  out  1  1 = timeout or illegal op.
- busy  out  1  high whenever state != IDLE.
- cam_chip_enable  out  1  to subarray chip_enable.
- cam_operation_mode  out  3
- cam_addr_select  out  1
- cam_cmp_addr  out  10
- cam_ppg_addr  out  4
- cam_cmp_data  out  2
- cam_ppg_data  out  2
- cam_data_in  out  16
- cam_tag_in  out  16
- cam_update_signal  out  1
- cam_tag_out  in  16  subarray registered tag result.
- cam_write_done  in  1  subarray write/update completion pulse.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; all outputs 0 except cmd_ready=1; timeout counter=0.
- All cam_* outputs are registered. The accepted command fields are latched on handshake and held stable until return to IDLE.
- States: IDLE, ISSUE, WAIT_DONE, SEARCH, CAPTURE, RELEASE, RESP.
- IDLE: cmd_ready=1. On accept:
  - op=111 → RESP with rsp_err=1, rsp_tag=0. The subarray is never enabled.
  - op 000/001 → ISSUE.
  - op 010–110 → SEARCH.
- ISSUE: cam_chip_enable=1 with latched fields for exactly 1 cycle → WAIT_DONE (chip_enable stays 1).
- WAIT_DONE: hold chip_enable=1.
  - cam_write_done=1 → drop chip_enable next cycle and go to RELEASE, err=0.
  - Counter reaches DONE_TIMEOUT without write_done → RELEASE with err=1.
- SEARCH: cam_chip_enable=1 for exactly 1 cycle → CAPTURE with chip_enable=0.
- CAPTURE: sample cam_tag_out into rsp_tag (the subarray updated it on the SEARCH edge) → RELEASE.
- RELEASE: chip_enable=0 for one full cycle, which guarantees the subarray's write_done clears before the next command → RESP.
- RESP: rsp_valid=1 with rsp_tag/rsp_err held stable until rsp_ready; on handshake → IDLE, rsp_valid=0.
- Latency with rsp_ready tied high:
  - Write/update: accept → rsp_valid asserted 4 cycles later (ISSUE, WAIT_DONE, RELEASE, RESP).
  - Search: accept → rsp_valid asserted 4 cycles later (SEARCH, CAPTURE, RELEASE, RESP).
- A new command is accepted no earlier than the cycle after the rsp handshake. There is no pipelining; cmd_ready=0 outside IDLE.
- cam_write_done arriving outside WAIT_DONE is ignored.
- Response backpressure: holding rsp_ready=0 stalls in RESP indefinitely with chip_enable=0.
- Reset mid-operation (any state): immediate return to reset values next cycle. chip_enable drops and any pending response is discarded.

Test Plan:
- Write cmd (op=000, addr_sel=0, cmp_addr=5, data=16'hA5A5), write_done returned 1 cycle after ISSUE → chip_enable high 2 cycles, rsp_valid 4 cycles after accept, rsp_err=0, rsp_tag=0.
- Search op=010, cmp_addr=5, cmp_data=2'b01, cam_tag_out driven 16'hA5A5 after SEARCH edge → rsp_tag=16'hA5A5, chip_enable high exactly 1 cycle.
- Write with cam_write_done never asserted → after 15 cycles in WAIT_DONE, rsp_err=1, chip_enable=0, controller returns to IDLE after rsp handshake.
- Illegal op=111 → cam_chip_enable never asserted, rsp_valid next cycle with rsp_err=1, rsp_tag=0.
- Back-to-back update (op=001, tag=16'h00FF, update=1) then search with rsp_ready=0 for 5 cycles → response held stable, second cmd_ready only after handshake, at least one chip_enable-low cycle between commands.
- Assert rst during WAIT_DONE → next cycle all outputs zero, cmd_ready=1, no response emitted.

Source files
------------

// File: rtl/cam_subarray_ctrl.sv
// Sequencer that drives one CAM subarray operation port: one command in, one response out.
// Applies chip_enable around writes/updates (until write_done) and searches (single cycle).
module cam_subarray_ctrl #(
  parameter int unsigned DONE_TIMEOUT = 15,
  parameter int unsigned TO_W         = 4
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic        cmd_addr_sel,
  input  logic [9:0]  cmd_cmp_addr,
  input  logic [3:0]  cmd_ppg_addr,
  input  logic [1:0]  cmd_cmp_data,
  input  logic [1:0]  cmd_ppg_data,
  input  logic [15:0] cmd_data,
  input  logic [15:0] cmd_tag,
  input  logic        cmd_update,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_tag,
  output logic        rsp_err,
  output logic        busy,
  output logic        cam_chip_enable,
  output logic [2:0]  cam_operation_mode,
  output logic        cam_addr_select,
  output logic [9:0]  cam_cmp_addr,
  output logic [3:0]  cam_ppg_addr,
  output logic [1:0]  cam_cmp_data,
  output logic [1:0]  cam_ppg_data,
  output logic [15:0] cam_data_in,
  output logic [15:0] cam_tag_in,
  output logic        cam_update_signal,
  input  logic [15:0] cam_tag_out,
  input  logic        cam_write_done
);

  localparam int unsigned TAG_W = 16;
  localparam logic [2:0] OP_WRITE   = 3'b000;
  localparam logic [2:0] OP_UPDATE  = 3'b001;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_SEARCH,
    S_CAPTURE,
    S_RELEASE,
    S_RESP
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [TO_W-1:0]  to_cnt;
  logic [TO_W-1:0]  to_cnt_nx;
  logic             ce_nx;
  logic             rsp_valid_nx;
  logic             rsp_err_nx;
  logic [TAG_W-1:0] rsp_tag_nx;
  logic             accept_c;

  // cmd_ready is only ever high in IDLE, so this is the handshake
  assign accept_c = cmd_valid & cmd_ready;

  // Next-state and next-output values; every registered output follows from these
  always_comb begin
    state_nx     = state;
    to_cnt_nx    = '0;
    ce_nx        = 1'b0;
    rsp_valid_nx = 1'b0;
    rsp_tag_nx   = rsp_tag;
    rsp_err_nx   = rsp_err;
    unique case (state)
      S_IDLE: begin
        if (accept_c) begin
          rsp_tag_nx = '0;
          rsp_err_nx = 1'b0;
          if (cmd_op == OP_ILLEGAL) begin
            state_nx     = S_RESP;
            rsp_err_nx   = 1'b1;
            rsp_valid_nx = 1'b1;
          end else if (cmd_op == OP_WRITE || cmd_op == OP_UPDATE) begin
            state_nx = S_ISSUE;
            ce_nx    = 1'b1;
          end else begin
            state_nx = S_SEARCH;
            ce_nx    = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        state_nx = S_WAIT_DONE;
        ce_nx    = 1'b1;
      end
      S_WAIT_DONE: begin
        if (cam_write_done) begin
          state_nx = S_RELEASE;
        end else if (to_cnt == TO_LAST) begin
          state_nx   = S_RELEASE;
          rsp_err_nx = 1'b1;
        end else begin
          ce_nx     = 1'b1;
          to_cnt_nx = to_cnt + TO_W'(1);
        end
      end
      S_SEARCH: begin
        state_nx = S_CAPTURE;
      end
      S_CAPTURE: begin
        // subarray registered its result on the SEARCH edge
        rsp_tag_nx = cam_tag_out;
        state_nx   = S_RELEASE;
      end
      S_RELEASE: begin
        state_nx     = S_RESP;
        rsp_valid_nx = 1'b1;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nx = S_IDLE;
        end else begin
          rsp_valid_nx = 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State, counter and all registered outputs
  always_ff @(posedge CLK) begin
    if (rst) begin
      state              <= S_IDLE;
      to_cnt             <= '0;
      cmd_ready          <= 1'b1;
      busy               <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_tag            <= '0;
      rsp_err            <= 1'b0;
      cam_chip_enable    <= 1'b0;
      cam_operation_mode <= '0;
      cam_addr_select    <= 1'b0;
      cam_cmp_addr       <= '0;
      cam_ppg_addr       <= '0;
      cam_cmp_data       <= '0;
      cam_ppg_data       <= '0;
      cam_data_in        <= '0;
      cam_tag_in         <= '0;
      cam_update_signal  <= 1'b0;
    end else begin
      state           <= state_nx;
      to_cnt          <= to_cnt_nx;
      cmd_ready       <= (state_nx == S_IDLE);
      busy            <= (state_nx != S_IDLE);
      rsp_valid       <= rsp_valid_nx;
      rsp_tag         <= rsp_tag_nx;
      rsp_err         <= rsp_err_nx;
      cam_chip_enable <= ce_nx;
      if (accept_c) begin
        cam_operation_mode <= cmd_op;
        cam_addr_select    <= cmd_addr_sel;
        cam_cmp_addr       <= cmd_cmp_addr;
        cam_ppg_addr       <= cmd_ppg_addr;
        cam_cmp_data       <= cmd_cmp_data;
        cam_ppg_data       <= cmd_ppg_data;
        cam_data_in        <= cmd_data;
        cam_tag_in         <= cmd_tag;
        cam_update_signal  <= cmd_update;
      end
    end
  end

endmodule
